// File: rtl/pwm_servo_driver_if.sv
// rtl/pwm_servo_driver_if.sv - control word valid/ready handshake into the servo PWM driver
interface pwm_servo_driver_if #(
    parameter int N = 18
);
    logic signed [N-1:0] proporcional;
    logic                valid_in;
    logic                ready;

    modport master (output proporcional, output valid_in, input ready);
    modport slave  (input proporcional, input valid_in, output ready);
endinterface

// File: rtl/pwm_servo_driver.sv
// rtl/pwm_servo_driver.sv - signed control word to PWM duty + direction, optional deadband via PWM_DEADBAND_EN
module pwm_servo_driver #(
    parameter int Magnitud    = 17,
    parameter int Decimal     = 0,
    parameter int N           = Magnitud + Decimal + 1,
    parameter int PERIODO     = 1000,
    parameter int ZONA_MUERTA = 20
) (
    input  logic                 clk,
    input  logic                 reset_n,
    pwm_servo_driver_if.slave    cmd,
    input  logic                 enable,
    output logic                 pwm_out,
    output logic                 dir_out,
    output logic                 periodo_inicio,
    output logic                 saturado
);
    localparam int W = $clog2(PERIODO + 1);
    localparam logic [N-1:0] PER_N  = N'(PERIODO);
    localparam logic [W-1:0] PER_W  = W'(PERIODO);
    localparam logic [W-1:0] PER_M1 = W'(PERIODO - 1);
`ifdef PWM_DEADBAND_EN
    localparam logic [N-1:0] ZM_N   = N'(ZONA_MUERTA);
`endif

    typedef enum logic {IDLE, RUN} state_e;

    state_e         state_q, state_d;
    logic [W-1:0]   cnt_q, cnt_d;
    logic           buf_full_q, buf_full_d;
    logic [W-1:0]   buf_duty_q, buf_duty_d;
    logic           buf_dir_q, buf_dir_d;
    logic           buf_sat_q, buf_sat_d;
    logic [W-1:0]   act_duty_q, act_duty_d;
    logic           act_dir_q, act_dir_d;
    logic           act_sat_q, act_sat_d;
    logic           pwm_q, pwm_d;
    logic           inicio_q, inicio_d;

    logic [N-1:0]   abs_w, mag_w;
    logic [W-1:0]   conv_duty;
    logic           conv_dir, conv_sat;
    logic           accept, boundary;

    // N-bit magnitude so the most negative word maps to 2^(N-1) instead of wrapping
    always_comb begin
        conv_dir  = cmd.proporcional[N-1];
        abs_w     = conv_dir ? (~cmd.proporcional + 1'b1) : cmd.proporcional;
        mag_w     = abs_w >> Decimal;
        conv_sat  = (mag_w > PER_N);
        conv_duty = conv_sat ? PER_W : mag_w[W-1:0];
`ifdef PWM_DEADBAND_EN
        if (mag_w < ZM_N) begin
            conv_duty = '0;
            conv_dir  = 1'b0;
        end
`endif
    end

    always_comb begin
        accept     = cmd.valid_in && !buf_full_q;
        boundary   = (state_q == RUN) && (cnt_q == PER_M1);
        buf_full_d = buf_full_q;
        buf_duty_d = buf_duty_q;
        buf_dir_d  = buf_dir_q;
        buf_sat_d  = buf_sat_q;
        act_duty_d = act_duty_q;
        act_dir_d  = act_dir_q;
        act_sat_d  = act_sat_q;
        state_d    = state_q;
        cnt_d      = cnt_q;

        if (boundary && buf_full_q) begin
            act_duty_d = buf_duty_q;
            act_dir_d  = buf_dir_q;
            act_sat_d  = buf_sat_q;
            buf_full_d = 1'b0;
        end
        // accept needs an empty buffer, so it never collides with the boundary load
        if (accept) begin
            buf_duty_d = conv_duty;
            buf_dir_d  = conv_dir;
            buf_sat_d  = conv_sat;
            buf_full_d = 1'b1;
        end

        if (enable) begin
            state_d = RUN;
            cnt_d   = (state_q == RUN && !boundary) ? cnt_q + 1'b1 : '0;
        end else begin
            state_d = IDLE;
            cnt_d   = '0;
        end

        pwm_d    = (state_d == RUN) && (cnt_d < act_duty_d);
        inicio_d = (state_d == RUN) && (cnt_d == '0);
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            buf_full_q <= 1'b0;
            buf_duty_q <= '0;
            buf_dir_q  <= 1'b0;
            buf_sat_q  <= 1'b0;
            act_duty_q <= '0;
            act_dir_q  <= 1'b0;
            act_sat_q  <= 1'b0;
            pwm_q      <= 1'b0;
            inicio_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            buf_full_q <= buf_full_d;
            buf_duty_q <= buf_duty_d;
            buf_dir_q  <= buf_dir_d;
            buf_sat_q  <= buf_sat_d;
            act_duty_q <= act_duty_d;
            act_dir_q  <= act_dir_d;
            act_sat_q  <= act_sat_d;
            pwm_q      <= pwm_d;
            inicio_q   <= inicio_d;
        end
    end

    assign cmd.ready      = !buf_full_q;
    assign pwm_out        = pwm_q;
    assign periodo_inicio = inicio_q;
    assign dir_out        = act_dir_q;
    assign saturado       = act_sat_q;
endmodule
